// File: rtl/cskip_pkg.sv
// Shared types and default sizing for the slice-serial carry-skip subtractor.
// Optional signed-overflow output is enabled by defining CSKIP_SUB_OVF_EN.
package cskip_pkg;

  localparam int unsigned CSKIP_WIDTH  = 32;
  localparam int unsigned CSKIP_BLOCK  = 4;
  localparam int unsigned CSKIP_NSLICE = CSKIP_WIDTH / CSKIP_BLOCK;
  localparam int unsigned CSKIP_CNT_W  = (CSKIP_NSLICE > 1) ? $clog2(CSKIP_NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width for an arbitrary slice count; a single slice still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cskip_sub32_seq_if.sv
// Operand/result valid-ready bus of the slice-serial subtractor.
// The ovf signal exists only when CSKIP_SUB_OVF_EN is defined.
interface cskip_sub32_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef CSKIP_SUB_OVF_EN
  logic             ovf;
`endif

  // Producer/consumer side
  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
`ifdef CSKIP_SUB_OVF_EN
    input  ovf,
`endif
    input  borrow
  );

  // Subtractor side
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
`ifdef CSKIP_SUB_OVF_EN
    output ovf,
`endif
    output borrow
  );

endinterface

// File: rtl/cskip_sub_slice.sv
// Combinational BLOCK-bit ripple adder slice with a propagate-AND carry-skip mux.
module cskip_sub_slice #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] nb_i,
  input  logic             c_i,
  output logic [BLOCK-1:0] sum_c,
  output logic             cout_c
);

  logic [BLOCK:0]   rc;
  logic [BLOCK-1:0] prop;

  // Ripple path; the skip mux bypasses it when every bit propagates
  always_comb begin
    rc    = '0;
    prop  = '0;
    sum_c = '0;
    rc[0] = c_i;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      prop[i]  = a_i[i] ^ nb_i[i];
      sum_c[i] = prop[i] ^ rc[i];
      rc[i+1]  = (a_i[i] & nb_i[i]) | (prop[i] & rc[i]);
    end
    cout_c = (&prop) ? c_i : rc[BLOCK];
  end

endmodule

// File: rtl/cskip_sub32_seq.sv
// Multi-cycle subtractor: diff = a - b computed one BLOCK-bit carry-skip slice per clock.
// Define CSKIP_SUB_OVF_EN to add the registered signed-overflow output ovf.
module cskip_sub32_seq
  import cskip_pkg::*;
#(
  parameter int unsigned WIDTH = CSKIP_WIDTH,
  parameter int unsigned BLOCK = CSKIP_BLOCK
) (
  input logic              clk,
  input logic              rst_n,
  cskip_sub32_seq_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / BLOCK;
  localparam int unsigned CNT_W  = cnt_width(NSLICE);
  localparam int unsigned LAST   = NSLICE - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef CSKIP_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [BLOCK-1:0] a_sl_c;
  logic [BLOCK-1:0] nb_sl_c;
  logic [BLOCK-1:0] sum_sl_c;
  logic             cout_sl_c;
  logic             last_c;

  assign last_c = (cnt_q == CNT_W'(LAST));

  // Select the operand slice addressed by the slice counter
  always_comb begin
    a_sl_c  = '0;
    nb_sl_c = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_sl_c  = a_q[i*BLOCK +: BLOCK];
        nb_sl_c = nb_q[i*BLOCK +: BLOCK];
      end
    end
  end

  cskip_sub_slice #(
    .BLOCK (BLOCK)
  ) u_slice (
    .a_i    (a_sl_c),
    .nb_i   (nb_sl_c),
    .c_i    (carry_q),
    .sum_c  (sum_sl_c),
    .cout_c (cout_sl_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_RUN;
      S_RUN:  if (last_c)       state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_d         = a_q;
    nb_d        = nb_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef CSKIP_SUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // a - b is formed as a + ~b + 1
          a_d        = bus.a;
          nb_d       = ~bus.b;
          carry_d    = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      S_RUN: begin
        carry_d = cout_sl_c;
        for (int unsigned i = 0; i < NSLICE; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            diff_d[i*BLOCK +: BLOCK] = sum_sl_c;
          end
        end
        if (last_c) begin
          cnt_d       = '0;
          borrow_d    = ~cout_sl_c;
          out_valid_d = 1'b1;
`ifdef CSKIP_SUB_OVF_EN
          // Operand signs differ (a msb equals ~b msb) and result sign differs from a
          ovf_d = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sum_sl_c[BLOCK-1] != a_q[WIDTH-1]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      nb_q        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CSKIP_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      nb_q        <= nb_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef CSKIP_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
`ifdef CSKIP_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cskip_sub32_seq.sv
// Self-checking bench for cskip_sub32_seq: directed plan vectors plus randomized operands
// checked against plain 32-bit arithmetic.
module tb_cskip_sub32_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned BL = 4;
  localparam int unsigned NS = W / BL;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cskip_sub32_seq_if #(.WIDTH(W)) bus ();

  cskip_sub32_seq #(
    .WIDTH (W),
    .BLOCK (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain unsigned/signed arithmetic
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return x - y;
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, sd;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sd = sx - sy;
    return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
  endfunction

  // Wait up to 'limit' edges for in_ready; returns 1 when it was seen
  task automatic wait_ready(input int limit, output bit ok);
    int n;
    n = 0;
    while (!bus.in_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
  endtask

  // One full transaction; 'hold' cycles of backpressure, 'poke' fires a stray in_valid in DONE
  task automatic do_txn(input logic [W-1:0] av, input logic [W-1:0] bv, input int hold,
                        input bit poke, input string tag);
    logic [W-1:0] ed;
    logic         eb;
    bit           ok;
    int           lat;
    ed = ref_diff(av, bv);
    eb = ref_borrow(av, bv);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    wait_ready(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept_timeout in_ready=%b required 1", tag, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== int'(NS + 1)) begin
      errors++;
      $display("FAIL %s latency got %0d required %0d", tag, lat, NS + 1);
    end
    checks++;
    if (bus.diff !== ed) begin
      errors++;
      $display("FAIL %s diff got %h required %h", tag, bus.diff, ed);
    end
    checks++;
    if (bus.borrow !== eb) begin
      errors++;
      $display("FAIL %s borrow got %b required %b", tag, bus.borrow, eb);
    end
`ifdef CSKIP_SUB_OVF_EN
    checks++;
    if (bus.ovf !== ref_ovf(av, bv)) begin
      errors++;
      $display("FAIL %s ovf got %b required %b", tag, bus.ovf, ref_ovf(av, bv));
    end
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (poke && i == 1) begin
        bus.in_valid = 1'b1;
        bus.a        = ~av;
        bus.b        = av;
      end else begin
        bus.in_valid = 1'b0;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== ed || bus.borrow !== eb) begin
        errors++;
        $display("FAIL %s hold%0d ov=%b ir=%b diff=%h bw=%b required ov=1 ir=0 diff=%h bw=%b",
                 tag, i, bus.out_valid, bus.in_ready, bus.diff, bus.borrow, ed, eb);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release ov=%b ir=%b required ov=0 ir=1", tag, bus.out_valid, bus.in_ready);
    end
    if (poke) begin
      // The stray request in DONE must not have started a new run
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s stray_capture ov=%b ir=%b required ov=0 ir=1", tag, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== '0 || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset ir=%b ov=%b diff=%h bw=%b required ir=1 ov=0 diff=0 bw=0",
               bus.in_ready, bus.out_valid, bus.diff, bus.borrow);
    end
`ifdef CSKIP_SUB_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b required 0", bus.ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_txn(32'h0000_0005, 32'h0000_0003, 0, 1'b0, "small");
    do_txn(32'h0000_0000, 32'h0000_0001, 0, 1'b0, "underflow");
    do_txn(32'h8000_0000, 32'h0000_0001, 0, 1'b0, "signed_ovf");
    do_txn(32'hA0A0_E1FF, 32'hA0A0_E1FF, 0, 1'b0, "full_skip");
    do_txn(32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0, "max_minus_zero");
  endtask

  task automatic test_backpressure();
    do_txn(32'h5800_FFF4, 32'hF4F4_FF07, 5, 1'b1, "backpressure");
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    for (int i = 0; i < 24; i++) begin
      av = $urandom;
      case (i % 4)
        0:       bv = av;
        1:       bv = av + W'($urandom_range(0, 3));
        default: bv = $urandom;
      endcase
      do_txn(av, bv, int'($urandom_range(0, 3)), 1'b0, "random");
    end
  endtask

  // Simultaneous in_valid and out_ready in DONE: only the result transfers
  task automatic test_back_to_back();
    logic [W-1:0] a2, b2;
    bit           ok;
    int           lat;
    a2 = 32'h1234_5678;
    b2 = 32'h8765_4321;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'h0000_0010;
    bus.b        = 32'h0000_0020;
    wait_ready(40, ok);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.diff !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL b2b_first ov=%b diff=%h required ov=1 diff=fffffff0", bus.out_valid, bus.diff);
    end
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a2;
    bus.b         = b2;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_transfer ov=%b ir=%b required ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept in_ready=%b required 0", bus.in_ready);
    end
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== int'(NS + 1) || bus.diff !== ref_diff(a2, b2) || bus.borrow !== ref_borrow(a2, b2)) begin
      errors++;
      $display("FAIL b2b_second lat=%0d diff=%h bw=%b required lat=%0d diff=%h bw=%b",
               lat, bus.diff, bus.borrow, NS + 1, ref_diff(a2, b2), ref_borrow(a2, b2));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h0BAD_F00D;
    wait_ready(40, ok);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== '0 || bus.borrow !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset ov=%b ir=%b diff=%h bw=%b required ov=0 ir=1 diff=0 bw=0",
               bus.out_valid, bus.in_ready, bus.diff, bus.borrow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(32'h0000_1000, 32'h0000_0001, 2, 1'b0, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
